// File: rtl/frame_timing_ctrl.sv
// Frame/line timing controller: sequences fval/lval from a per-frame latched config and
// pulls CHANNEL_NUM pixels per beat from a show-ahead source while a line is active.
module frame_timing_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_enable,
  input  logic [CNT_WIDTH-1:0]              iv_fval_lead,
  input  logic [CNT_WIDTH-1:0]              iv_line_active,
  input  logic [CNT_WIDTH-1:0]              iv_line_blank,
  input  logic [CNT_WIDTH-1:0]              iv_frame_lines,
  input  logic [CNT_WIDTH-1:0]              iv_fval_trail,
  input  logic [CNT_WIDTH-1:0]              iv_frame_blank,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_src_data,
  output logic                              o_src_req,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done
);

  localparam int unsigned PIX_W = DATA_WIDTH * CHANNEL_NUM;

  typedef enum logic [2:0] {IDLE, LEAD, ACT, LBLANK, TRAIL, FBLANK} state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] fval_lead;
    logic [CNT_WIDTH-1:0] line_active;
    logic [CNT_WIDTH-1:0] line_blank;
    logic [CNT_WIDTH-1:0] frame_lines;
    logic [CNT_WIDTH-1:0] fval_trail;
    logic [CNT_WIDTH-1:0] frame_blank;
  } cfg_t;

  state_t               state, state_nx;
  cfg_t                 cfg, cfg_nx, cfg_in;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx;
  logic [CNT_WIDTH-1:0] line_cnt, line_cnt_nx;
  logic                 fval_nx, lval_nx, done_nx;
  logic [PIX_W-1:0]     pix_nx;
  logic                 start_ok;
  state_t               start_state;

  assign cfg_in = {iv_fval_lead, iv_line_active, iv_line_blank,
                   iv_frame_lines, iv_fval_trail, iv_frame_blank};

  // A frame may only start from a non-empty geometry; zero lead skips straight to the line.
  assign start_ok    = i_enable && (iv_line_active != '0) && (iv_frame_lines != '0);
  assign start_state = (iv_fval_lead != '0) ? LEAD : ACT;

  assign o_src_req = (state == ACT);

  // Next-state, counters and registered-output values.
  always_comb begin
    state_nx    = state;
    cfg_nx      = cfg;
    cnt_nx      = cnt + CNT_WIDTH'(1);
    line_cnt_nx = line_cnt;
    fval_nx     = (state == LEAD) || (state == ACT) || (state == LBLANK) || (state == TRAIL);
    lval_nx     = (state == ACT);
    pix_nx      = (state == ACT) ? iv_src_data : '0;
    // FBLANK is only ever entered with cnt cleared, so cnt==0 marks its first cycle.
    done_nx     = (state == FBLANK) && (cnt == '0);

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start_ok) begin
          cfg_nx      = cfg_in;
          line_cnt_nx = '0;
          state_nx    = start_state;
        end
      end
      LEAD: begin
        if (cnt == cfg.fval_lead - CNT_WIDTH'(1)) begin
          cnt_nx   = '0;
          state_nx = ACT;
        end
      end
      ACT: begin
        if (cnt == cfg.line_active - CNT_WIDTH'(1)) begin
          cnt_nx = '0;
          if (line_cnt == cfg.frame_lines - CNT_WIDTH'(1)) begin
            line_cnt_nx = '0;
            state_nx    = (cfg.fval_trail != '0) ? TRAIL : FBLANK;
          end else begin
            line_cnt_nx = line_cnt + CNT_WIDTH'(1);
            state_nx    = (cfg.line_blank != '0) ? LBLANK : ACT;
          end
        end
      end
      LBLANK: begin
        if (cnt == cfg.line_blank - CNT_WIDTH'(1)) begin
          cnt_nx   = '0;
          state_nx = ACT;
        end
      end
      TRAIL: begin
        if (cnt == cfg.fval_trail - CNT_WIDTH'(1)) begin
          cnt_nx   = '0;
          state_nx = FBLANK;
        end
      end
      FBLANK: begin
        if ((cfg.frame_blank == '0) || (cnt == cfg.frame_blank - CNT_WIDTH'(1))) begin
          cnt_nx = '0;
          if (start_ok) begin
            cfg_nx      = cfg_in;
            line_cnt_nx = '0;
            state_nx    = start_state;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        cnt_nx      = '0;
        line_cnt_nx = '0;
        state_nx    = IDLE;
      end
    endcase
  end

  // State, config and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cfg          <= '0;
      cnt          <= '0;
      line_cnt     <= '0;
      o_fval       <= 1'b0;
      o_lval       <= 1'b0;
      ov_pix_data  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nx;
      cfg          <= cfg_nx;
      cnt          <= cnt_nx;
      line_cnt     <= line_cnt_nx;
      o_fval       <= fval_nx;
      o_lval       <= lval_nx;
      ov_pix_data  <= pix_nx;
      o_frame_done <= done_nx;
    end
  end

endmodule

// File: tb/tb_frame_timing_ctrl.sv
// Bench for frame_timing_ctrl: show-ahead source feeding a pixel scoreboard, plus a
// per-frame shape monitor for fval/lval/frame_done.
module tb_frame_timing_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = DW * CH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [CW-1:0] iv_fval_lead = '0, iv_line_active = '0, iv_line_blank = '0;
  logic [CW-1:0] iv_frame_lines = '0, iv_fval_trail = '0, iv_frame_blank = '0;
  logic [PW-1:0] iv_src_data;
  logic          o_src_req, o_fval, o_lval, o_frame_done;
  logic [PW-1:0] ov_pix_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] exp_q[$];

  // Per-frame monitor state and records of the last finished frame.
  int  f_len = 0, f_lead = 0, f_req = 0, on_len = 0, gap_len = 0, fgap = 0;
  int  on_runs[$], off_runs[$];
  bit  seen_lval = 0, prev_fval = 0, prev_lval = 0, prev_done = 0;
  int  r_len, r_lead, r_trail, r_req, r_on_n, r_on0, r_on1, r_off_n, r_off0, r_gap;
  int  frames_done = 0, rises = 0, req_total = 0;

  frame_timing_ctrl #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable),
    .iv_fval_lead(iv_fval_lead), .iv_line_active(iv_line_active),
    .iv_line_blank(iv_line_blank), .iv_frame_lines(iv_frame_lines),
    .iv_fval_trail(iv_fval_trail), .iv_frame_blank(iv_frame_blank),
    .iv_src_data(iv_src_data), .o_src_req(o_src_req), .o_fval(o_fval),
    .o_lval(o_lval), .ov_pix_data(ov_pix_data), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [PW-1:0] src_word(input int n);
    logic [PW-1:0] w;
    for (int l = 0; l < int'(CH); l++) w[l*DW +: DW] = DW'(n * int'(CH) + l);
    return w;
  endfunction

  // Show-ahead source: a word presented while src_req is high is consumed at the next edge.
  initial begin
    int  beat = 0;
    bit  take;
    iv_src_data = src_word(0);
    forever begin
      @(negedge clk);
      take = o_src_req;
      if (take) exp_q.push_back(iv_src_data);
      @(posedge clk);
      #1;
      if (take) begin
        beat++;
        iv_src_data = src_word(beat);
      end
    end
  end

  // Output monitor: pixel scoreboard, output invariants and frame shape bookkeeping.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      on_runs.delete();
      off_runs.delete();
      f_len = 0; f_lead = 0; f_req = 0; on_len = 0; gap_len = 0; fgap = 0;
      seen_lval = 0; prev_fval = 0; prev_lval = 0; prev_done = 0;
    end else begin
      if (o_lval) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
        else check("pix", ov_pix_data, exp_q.pop_front());
        check("lval_needs_fval", 32'(o_fval), 1);
      end else begin
        check("pix_zero", ov_pix_data, 0);
      end
      if (o_src_req) begin f_req++; req_total++; end
      if (o_fval) begin
        f_len++;
        if (!seen_lval && !o_lval) f_lead++;
        if (!prev_fval) begin r_gap = fgap; rises++; end
        fgap = 0;
      end else begin
        fgap++;
      end
      if (o_lval) begin
        if (!prev_lval) begin
          if (seen_lval) off_runs.push_back(gap_len);
          on_len = 0;
        end
        on_len++; seen_lval = 1; gap_len = 0;
      end else begin
        if (prev_lval) on_runs.push_back(on_len);
        if (o_fval && seen_lval) gap_len++;
      end
      if (o_frame_done) begin
        check("done_fval_low", 32'(o_fval), 0);
        check("done_after_fval", 32'(prev_fval), 1);
        check("done_one_clk", 32'(prev_done), 0);
        r_len = f_len; r_lead = f_lead; r_trail = gap_len; r_req = f_req;
        r_on_n = on_runs.size();  r_on0 = (r_on_n > 0) ? on_runs[0] : 0;
        r_on1 = (r_on_n > 1) ? on_runs[1] : 0;
        r_off_n = off_runs.size(); r_off0 = (r_off_n > 0) ? off_runs[0] : 0;
        frames_done++;
        on_runs.delete(); off_runs.delete();
        f_len = 0; f_lead = 0; f_req = 0; gap_len = 0; seen_lval = 0;
      end
      prev_fval = o_fval; prev_lval = o_lval; prev_done = o_frame_done;
    end
  end

  task automatic set_cfg(input int lead, input int act, input int lblank,
                         input int lines, input int trail, input int fblank);
    iv_fval_lead = CW'(lead);   iv_line_active = CW'(act);  iv_line_blank = CW'(lblank);
    iv_frame_lines = CW'(lines); iv_fval_trail = CW'(trail); iv_frame_blank = CW'(fblank);
  endtask

  task automatic wait_frames(input string tag, input int n);
    int target = frames_done + n;
    for (int i = 0; i < 400 && frames_done < target; i++) @(posedge clk);
    check({tag, "_timeout"}, 32'(frames_done >= target), 1);
  endtask

  task automatic wait_rise(input string tag);
    int r0 = rises;
    for (int i = 0; i < 200 && rises == r0; i++) @(posedge clk);
    check({tag, "_timeout"}, 32'(rises != r0), 1);
  endtask

  task automatic wait_lval(input string tag);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = o_lval;
    end
    check({tag, "_timeout"}, 32'(seen), 1);
  endtask

  task automatic check_frame(input string tag, input int len, input int lead,
                             input int on_n, input int on0, input int on1,
                             input int off_n, input int off0, input int trail, input int req);
    check({tag, "_fval_len"}, 32'(r_len), 32'(len));
    check({tag, "_lead"},     32'(r_lead), 32'(lead));
    check({tag, "_lines"},    32'(r_on_n), 32'(on_n));
    check({tag, "_line0"},    32'(r_on0), 32'(on0));
    check({tag, "_line1"},    32'(r_on1), 32'(on1));
    check({tag, "_gaps"},     32'(r_off_n), 32'(off_n));
    check({tag, "_gap0"},     32'(r_off0), 32'(off0));
    check({tag, "_trail"},    32'(r_trail), 32'(trail));
    check({tag, "_src_req"},  32'(r_req), 32'(req));
  endtask

  task automatic check_quiet(input string tag);
    int r0 = rises, q0 = req_total;
    repeat (40) @(posedge clk);
    check({tag, "_no_fval"}, 32'(rises - r0), 0);
    check({tag, "_no_req"},  32'(req_total - q0), 0);
    @(negedge clk);
    check({tag, "_fval_low"}, 32'(o_fval), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_fval", 32'(o_fval), 0);
    check("rst_lval", 32'(o_lval), 0);
    check("rst_data", ov_pix_data, 0);
    check("rst_done", 32'(o_frame_done), 0);
    check("rst_req",  32'(o_src_req), 0);
    reset_n = 1'b1;

    // Nominal frame shape with enable held, then the frame-blank gap.
    set_cfg(2, 4, 3, 2, 1, 5);
    i_enable = 1'b1;
    wait_frames("f1", 1);
    check_frame("f1", 14, 2, 2, 4, 4, 1, 3, 1, 8);
    wait_rise("f2_start");
    check("f2_gap", 32'(r_gap), 5);

    // Mid-frame config change only applies to the following frame.
    repeat (4) @(posedge clk);
    set_cfg(0, 4, 0, 2, 0, 0);
    wait_frames("f2", 1);
    check_frame("f2", 14, 2, 2, 4, 4, 1, 3, 1, 8);
    wait_rise("f3_start");
    check("f3_gap", 32'(r_gap), 5);
    set_cfg(2, 4, 3, 2, 1, 5);
    wait_frames("f3", 1);
    check_frame("f3", 8, 0, 1, 8, 0, 0, 0, 0, 8);
    wait_rise("f4_start");
    check("f4_gap", 32'(r_gap), 1);

    // Enable dropped in line 1: frame still completes, then the block idles.
    wait_lval("f4_line");
    i_enable = 1'b0;
    wait_frames("f4", 1);
    check_frame("f4", 14, 2, 2, 4, 4, 1, 3, 1, 8);
    check_quiet("stop");

    // Degenerate geometries never start a frame.
    @(negedge clk);
    set_cfg(2, 4, 3, 0, 1, 5);
    i_enable = 1'b1;
    check_quiet("zero_lines");
    @(negedge clk);
    set_cfg(2, 0, 3, 2, 1, 5);
    check_quiet("zero_active");

    // Asynchronous reset mid-line, then a clean restart.
    @(negedge clk);
    set_cfg(2, 4, 3, 2, 1, 5);
    wait_lval("rst_line");
    #2 reset_n = 1'b0;
    #1;
    check("arst_fval", 32'(o_fval), 0);
    check("arst_lval", 32'(o_lval), 0);
    check("arst_data", ov_pix_data, 0);
    check("arst_req",  32'(o_src_req), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frames("f5", 1);
    check_frame("f5", 14, 2, 2, 4, 4, 1, 3, 1, 8);

    i_enable = 1'b0;
    repeat (30) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
